// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract datapath:
// slice width, sequencer state encoding and the signed-overflow helper.
package addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow of b + (a ^ op): the effective operands share
    // a sign and the sum's sign differs from it.
    function automatic logic ovf_calc(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb,
        input logic op
    );
        return (((a_msb ^ op) == b_msb) && (s_msb != b_msb)) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/serial_addsub_ctrl_addsub.sv
// 4-bit add/subtract stage: s = (a ^ {4{op}}) + b + xin, co_bo = carry out of bit 3.
// Purely combinational; the sequencer registers everything it needs.
module addsub (
    input  logic       op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       xin,
    output logic [3:0] s,
    output logic       co_bo
);

    logic [4:0] total_s;

    // One 5-bit addition yields both the nibble sum and its carry out.
    always_comb begin
        total_s = {1'b0, a ^ {4{op}}} + {1'b0, b} + {4'b0000, xin};
    end

    assign s     = total_s[3:0];
    assign co_bo = total_s[4];

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Nibble-serial add/subtract sequencer. Accepts a WIDTH-bit operand pair,
// runs it LSB-first through a single 4-bit addsub stage with the carry/borrow
// chained through a register, and presents the result with a valid/ready pair.
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          op,
    input  logic [NIBBLE_W*NIBBLES-1:0]   a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]   result,
    output logic                          co_bo,
    output logic                          ovf
);

    localparam int WIDTH = NIBBLE_W * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                      state_r;
    logic [CNT_W-1:0]            cnt_r;
    logic [WIDTH-1:0]            a_sh_r;
    logic [WIDTH-1:0]            b_sh_r;
    logic [WIDTH-1:0]            result_r;
    logic                        op_r;
    logic                        carry_r;
    logic                        co_bo_r;
    logic                        ovf_r;
    logic                        in_ready_r;
    logic                        out_valid_r;

    logic [NIBBLE_W-1:0]         stage_sum_s;
    logic                        stage_co_s;
    logic [WIDTH+NIBBLE_W-1:0]   result_cat_s;
    logic [WIDTH-1:0]            result_next_s;
    logic [WIDTH-1:0]            a_next_s;
    logic [WIDTH-1:0]            b_next_s;
    logic                        ovf_next_s;

    // The only arithmetic in the block: the current low nibbles of the shifters.
    addsub u_addsub (
        .op    (op_r),
        .a     (a_sh_r[NIBBLE_W-1:0]),
        .b     (b_sh_r[NIBBLE_W-1:0]),
        .xin   (carry_r),
        .s     (stage_sum_s),
        .co_bo (stage_co_s)
    );

    // Next-slice values: the new sum nibble enters at the top of the result,
    // operands move down one nibble; concatenation keeps NIBBLES=1 legal.
    always_comb begin
        result_cat_s  = {stage_sum_s, result_r};
        result_next_s = result_cat_s[WIDTH+NIBBLE_W-1:NIBBLE_W];
        a_next_s      = a_sh_r >> NIBBLE_W;
        b_next_s      = b_sh_r >> NIBBLE_W;
        ovf_next_s    = ovf_calc(a_sh_r[NIBBLE_W-1], b_sh_r[NIBBLE_W-1],
                                 stage_sum_s[NIBBLE_W-1], op_r);
    end

    // Sequencer FSM with its datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            result_r    <= '0;
            op_r        <= 1'b0;
            carry_r     <= 1'b0;
            co_bo_r     <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_sh_r     <= a;
                        b_sh_r     <= b;
                        op_r       <= op;
                        carry_r    <= op;
                        cnt_r      <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    result_r <= result_next_s;
                    carry_r  <= stage_co_s;
                    a_sh_r   <= a_next_s;
                    b_sh_r   <= b_next_s;
                    if (cnt_r == CNT_LAST) begin
                        co_bo_r     <= stage_co_s;
                        ovf_r       <= ovf_next_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign co_bo     = co_bo_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed self-checking bench for serial_addsub_ctrl (NIBBLES=4 and NIBBLES=1).
module tb_serial_addsub_ctrl;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        co_bo;
    logic        ovf;

    logic        in_valid1;
    logic        in_ready1;
    logic        op1;
    logic [3:0]  a1;
    logic [3:0]  b1;
    logic        out_valid1;
    logic        out_ready1;
    logic [3:0]  result1;
    logic        co_bo1;
    logic        ovf1;

    int n_assert;
    int n_fail;

    serial_addsub_ctrl #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .co_bo     (co_bo),
        .ovf       (ovf)
    );

    serial_addsub_ctrl #(.NIBBLES(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .op        (op1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .result    (result1),
        .co_bo     (co_bo1),
        .ovf       (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one operation, scramble the inputs afterwards, measure latency,
    // check the result, then drain it.
    task automatic do_op(input string tag, input logic o, input logic [15:0] av,
                         input logic [15:0] bv, input logic [15:0] er,
                         input logic ec, input logic eo);
        int n;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; a = av; b = bv;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; op = ~o;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd4);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_co_bo"}, 32'(co_bo), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        n_assert = 0;
        n_fail = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; op = 1'b0; a = 16'h0000; b = 16'h0000; out_ready = 1'b0;
        in_valid1 = 1'b0; op1 = 1'b0; a1 = 4'h0; b1 = 4'h0; out_ready1 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_result", 32'(result), 32'h0);
        check("rst_co_bo", 32'(co_bo), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // Basic add/subtract vectors
        do_op("add_basic", 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0);
        do_op("sub_borrow", 1'b1, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
        do_op("sub_noborrow", 1'b1, 16'h0003, 16'h0009, 16'h0006, 1'b1, 1'b0);
        do_op("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        do_op("add_ovf", 1'b0, 16'h0001, 16'h7FFF, 16'h8000, 1'b0, 1'b1);
        do_op("sub_ovf", 1'b1, 16'h0001, 16'h8000, 16'h7FFF, 1'b1, 1'b1);

        // Back-pressure in DONE with a competing in_valid
        @(negedge clk);
        in_valid = 1'b1; op = 1'b0; a = 16'h4000; b = 16'h4000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_latency", 32'(n), 32'd4);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = 1'b1; a = 16'h1111; b = 16'h2222;
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_result", 32'(result), 32'h8000);
            check("hold_co_bo", 32'(co_bo), 32'd0);
            check("hold_ovf", 32'(ovf), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold_release_valid", 32'(out_valid), 32'd0);
        check("hold_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("hold_no_accept", 32'(in_ready), 32'd1);

        // Reset in the 2nd RUN cycle
        in_valid = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h1111;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstrun_out_valid", 32'(out_valid), 32'd0);
        check("rstrun_state", 32'(dut.state_r), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_rst", 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);

        // Reset while a result is waiting in DONE
        @(negedge clk);
        in_valid = 1'b1; op = 1'b0; a = 16'h0F0F; b = 16'h0101;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstdone_pre_valid", 32'(out_valid), 32'd1);
        check("rstdone_pre_result", 32'(result), 32'h1010);
        rst_n = 1'b0;
        #1;
        check("rstdone_out_valid", 32'(out_valid), 32'd0);
        check("rstdone_state", 32'(dut.state_r), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // NIBBLES=1 instance
        @(negedge clk);
        check("n1_in_ready", 32'(in_ready1), 32'd1);
        in_valid1 = 1'b1; op1 = 1'b1; a1 = 4'h3; b1 = 4'h9;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0; a1 = 4'hF; b1 = 4'hF; op1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("n1_latency", 32'(n), 32'd1);
        check("n1_result", 32'(result1), 32'h6);
        check("n1_co_bo", 32'(co_bo1), 32'd1);
        check("n1_ovf", 32'(ovf1), 32'd1);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        check("n1_drain_valid", 32'(out_valid1), 32'd0);
        check("n1_drain_ready", 32'(in_ready1), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
